// File: rtl/caesar_stream_codec.sv
// caesar_stream_codec: streaming Caesar/Vigenere byte codec with a programmable rotating key table
module caesar_stream_codec #(
    parameter int KEY_DEPTH = 4,
    parameter bit PASS_NONALPHA = 1'b1,
    localparam int IW = KEY_DEPTH > 1 ? $clog2(KEY_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_key_we,
    input  logic [IW-1:0] cfg_addr,
    input  logic [4:0]    cfg_shift,
    input  logic          cfg_len_we,
    input  logic [IW:0]   cfg_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_mode,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last
);
    logic [4:0] key [KEY_DEPTH];
    logic [IW:0] len, len_w;
    logic [IW-1:0] idx;
    logic accept, is_lower, is_upper, letter;
    logic [4:0] k, s;
    logic [7:0] base, sum, coded;

    assign in_ready = !out_valid || out_ready;

    always_comb begin
        accept = in_valid && in_ready;
        is_lower = in_data >= 8'h61 && in_data <= 8'h7a;
        is_upper = in_data >= 8'h41 && in_data <= 8'h5a;
        letter = is_lower || is_upper;
        base = is_lower ? 8'h61 : 8'h41;
        k = key[idx];
        s = in_mode && k != 5'd0 ? 5'd26 - k : k;
        // adding the shift to the raw byte cannot overflow: 'z' + 25 < 0x100
        sum = in_data + {3'b000, s};
        coded = !letter ? (PASS_NONALPHA ? in_data : 8'h20) : sum > base + 8'd25 ? sum - 8'd26 : sum;
        len_w = cfg_len == '0 ? (IW+1)'(1) : cfg_len > (IW+1)'(KEY_DEPTH) ? (IW+1)'(KEY_DEPTH) : cfg_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            key <= '{default: '0};
            len <= (IW+1)'(1);
            idx <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data <= coded;
                out_last <= in_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (cfg_key_we && int'(cfg_addr) < KEY_DEPTH)
                key[cfg_addr] <= cfg_shift >= 5'd26 ? cfg_shift - 5'd26 : cfg_shift;
            if (cfg_len_we)
                len <= len_w;
            // a message boundary or a new key length restarts the key rotation
            if (cfg_len_we || (accept && in_last))
                idx <= '0;
            else if (accept && letter)
                idx <= {1'b0, idx} + 1'b1 >= len ? '0 : idx + 1'b1;
        end
    end
endmodule
